// File: rtl/iot_event_source_pkg.sv
// Shared types and constants for the IoT event source.
package iot_pkg;

    localparam int MAX_COUNT       = 255;
    localparam int DEFAULT_NUM_DEV = 8;

    // Stored device index is wide enough for any legal NUM_DEV (up to 255),
    // so the FIFO entry format does not depend on the instance parameters.
    localparam int REQ_DEV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [REQ_DEV_W-1:0] dev;
        logic                 on;
    } req_t;

endpackage

// File: rtl/iot_event_source_if.sv
// Request handshake bundle: producer drives valid/dev/on, source returns ready.
interface iot_req_if #(
    parameter int DEV_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [DEV_W-1:0] req_dev;
    logic             req_on;

    modport master (
        output req_valid,
        output req_dev,
        output req_on,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dev,
        input  req_on,
        output req_ready
    );
endinterface

// File: rtl/iot_event_source_req_fifo.sv
// Small request FIFO; flags derive from registered pointers, so a pop while
// full only reopens the write side on the following cycle.
module iot_req_fifo
    import iot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    req_t        mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer advance with natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/iot_event_source.sv
// Device-side event transmitter: filters on/off requests against the committed
// device bitmap and emits one change pulse per real transition.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting; staged request is evaluated every cycle
//   ST_ISSUE | change=1 this cycle, bitmap/count already committed
//   ST_GAP   | change forced low; last gap cycle may evaluate the next one
//
// A one-entry stage register sits between the FIFO and the evaluator, giving
// push -> stage -> issue latency. Evaluation is allowed in the final gap cycle
// so consecutive pulses are spaced exactly 1+GAP_CYCLES cycles.
module iot_event_source
    import iot_pkg::*;
#(
    parameter int NUM_DEV    = DEFAULT_NUM_DEV,
    parameter int DEV_W      = $clog2(NUM_DEV),
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    iot_req_if.slave           req,
    output logic               change,
    output logic               on_off,
    output logic [NUM_DEV-1:0] dev_state,
    output logic [7:0]         active_count,
    output logic [7:0]         redundant_count
);

    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t             state;
    state_t             next_state;
    logic [GAP_W-1:0]   gap_cnt;

    req_t               fifo_in;
    req_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    req_t               cur_req;
    logic               cur_valid;
    logic [NUM_DEV-1:0] dev_mask;
    logic               dev_ok;
    logic               cur_is_on;
    logic               cur_real;
    logic               eval_slot;
    logic               cur_take;
    logic               fire;
    logic               drop;

    logic               change_nxt;
    logic               on_off_nxt;

    assign fifo_in.dev  = REQ_DEV_W'(req.req_dev);
    assign fifo_in.on   = req.req_on;
    assign req.req_ready = !fifo_full;
    assign fifo_push    = req.req_valid && !fifo_full;

    iot_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One-hot select of the staged device; out-of-range indices select nothing.
    always_comb begin
        dev_mask = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            dev_mask[i] = (cur_req.dev == REQ_DEV_W'(i));
        end
    end

    assign dev_ok    = (cur_req.dev < REQ_DEV_W'(NUM_DEV));
    assign cur_is_on = |(dev_state & dev_mask);
    assign cur_real  = dev_ok && (cur_is_on != cur_req.on);

    // Cycles in which the staged request may be consumed.
    always_comb begin
        eval_slot = 1'b0;
        unique case (state)
            ST_IDLE:  eval_slot = 1'b1;
            ST_ISSUE: eval_slot = (GAP_CYCLES == 0);
            ST_GAP:   eval_slot = (gap_cnt == '0);
            default:  eval_slot = 1'b0;
        endcase
    end

    assign cur_take = cur_valid && eval_slot;
    assign fire     = cur_take && cur_real;
    assign drop     = cur_take && !cur_real;
    assign fifo_pop = !fifo_empty && (!cur_valid || cur_take);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // Next-state selection.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (fire) next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (fire)                 next_state = ST_ISSUE;
                else if (GAP_CYCLES > 0)  next_state = ST_GAP;
                else                      next_state = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt == '0) next_state = fire ? ST_ISSUE : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered output values for the coming cycle.
    always_comb begin
        change_nxt = fire;
        on_off_nxt = fire ? cur_req.on : on_off;
    end

    // Event outputs; on_off holds its last direction between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            change <= 1'b0;
            on_off <= 1'b0;
        end else begin
            change <= change_nxt;
            on_off <= on_off_nxt;
        end
    end

    // Gap down-counter, loaded when a pulse hands over to the gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (state == ST_ISSUE && next_state == ST_GAP) begin
            gap_cnt <= GAP_W'(GAP_LOAD);
        end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Stage register between the FIFO head and the evaluator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_valid <= 1'b0;
            cur_req   <= '0;
        end else if (fifo_pop) begin
            cur_valid <= 1'b1;
            cur_req   <= fifo_head;
        end else if (cur_take) begin
            cur_valid <= 1'b0;
        end
    end

    // Committed device bitmap and counters; updated on the edge that raises change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_state       <= '0;
            active_count    <= '0;
            redundant_count <= '0;
        end else begin
            if (fire) begin
                if (cur_req.on) begin
                    dev_state    <= dev_state | dev_mask;
                    active_count <= active_count + 8'd1;
                end else begin
                    dev_state    <= dev_state & ~dev_mask;
                    active_count <= active_count - 8'd1;
                end
            end
            if (drop && redundant_count != 8'(MAX_COUNT)) begin
                redundant_count <= redundant_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_iot_event_source.sv
// Self-checking bench for iot_event_source with a request-level reference model.
module tb_iot_event_source;
    import iot_pkg::*;

    localparam int NUM_DEV    = 12;
    localparam int DEV_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iot_req_if #(.DEV_W(DEV_W)) bus ();

    logic               change;
    logic               on_off;
    logic [NUM_DEV-1:0] dev_state;
    logic [7:0]         active_count;
    logic [7:0]         redundant_count;

    iot_event_source #(
        .NUM_DEV    (NUM_DEV),
        .DEV_W      (DEV_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (bus.slave),
        .change          (change),
        .on_off          (on_off),
        .dev_state       (dev_state),
        .active_count    (active_count),
        .redundant_count (redundant_count)
    );

    typedef struct {
        int dev;
        bit on;
    } tb_req_t;

    int                 checks   = 0;
    int                 failures = 0;
    int                 cyc      = 0;
    int                 acc_cyc  = 0;

    tb_req_t            acc_q[$];
    bit [NUM_DEV-1:0]   m_state;
    int                 m_red;
    int                 mon_counter;
    int                 pulse_cnt;
    int                 pulse_cyc[$];
    bit                 prev_change;
    bit                 ready_low_seen;
    bit                 mon_found;
    bit                 mon_exp_on;
    tb_req_t            mon_r;
    tb_req_t            acc_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted request in order.
    always @(posedge clk) begin
        if (rst && bus.req_valid && bus.req_ready) begin
            acc_r.dev = int'(bus.req_dev);
            acc_r.on  = bus.req_on;
            acc_q.push_back(acc_r);
        end
    end

    // Apply one request to the reference bitmap; returns 1 for a real transition.
    function automatic bit model_apply(input tb_req_t r);
        if (r.dev >= NUM_DEV) begin
            if (m_red < 255) m_red++;
            return 1'b0;
        end
        if (m_state[r.dev] == r.on) begin
            if (m_red < 255) m_red++;
            return 1'b0;
        end
        m_state[r.dev] = r.on;
        return 1'b1;
    endfunction

    // Pulse scoreboard: each pulse must match the next real transition in request order.
    always @(negedge clk) begin
        if (!rst) begin
            prev_change = 1'b0;
        end else begin
            if (!bus.req_ready) ready_low_seen = 1'b1;
            if (change) begin
                checks++;
                if (prev_change) begin
                    failures++;
                    $display("FAIL consecutive_change: change high in cycle %0d and the one before, required a gap", cyc);
                end
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                mon_counter += on_off ? 1 : -1;
                mon_found = 1'b0;
                while (!mon_found && acc_q.size() > 0) begin
                    mon_r = acc_q.pop_front();
                    if (model_apply(mon_r)) begin
                        mon_found  = 1'b1;
                        mon_exp_on = mon_r.on;
                    end
                end
                checks++;
                if (!mon_found) begin
                    failures++;
                    $display("FAIL unexpected_pulse: pulse at cycle %0d with no pending transition", cyc);
                end else if (on_off !== mon_exp_on || dev_state !== m_state ||
                             active_count !== 8'($countones(m_state))) begin
                    failures++;
                    $display("FAIL pulse_content: got on_off=%0b dev_state=%h active=%0d, expected on_off=%0b dev_state=%h active=%0d",
                             on_off, dev_state, active_count, mon_exp_on, m_state, $countones(m_state));
                end
            end
            prev_change = change;
        end
    end

    task automatic clear_model();
        acc_q.delete();
        pulse_cyc.delete();
        m_state     = '0;
        m_red       = 0;
        mon_counter = 0;
        pulse_cnt   = 0;
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.req_dev   = '0;
        bus.req_on    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        #10;
        rst = 1'b1;
    endtask

    task automatic push_req(input int d, input bit o);
        int n;
        bus.req_valid = 1'b1;
        bus.req_dev   = DEV_W'(d);
        bus.req_on    = o;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            failures++;
            $display("FAIL push_timeout: req_ready=%0b after %0d cycles, expected 1", bus.req_ready, n);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
        end
    endtask

    task automatic idle_bus();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (pulse_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (pulse_cnt != n) begin
            failures++;
            $display("FAIL pulse_count: got %0d pulses, expected %0d", pulse_cnt, n);
        end
    endtask

    // Let the pipeline drain, then fold trailing no-op requests into the model.
    task automatic settle(input int cycles);
        tb_req_t r;
        repeat (cycles) @(negedge clk);
        while (acc_q.size() > 0) begin
            r = acc_q.pop_front();
            checks++;
            if (model_apply(r)) begin
                failures++;
                $display("FAIL missing_pulse: dev=%0d on=%0b produced no pulse", r.dev, r.on);
            end
        end
        checks++;
        if (redundant_count !== 8'(m_red) || dev_state !== m_state ||
            active_count !== 8'($countones(m_state))) begin
            failures++;
            $display("FAIL final_state: got red=%0d dev_state=%h active=%0d, expected red=%0d dev_state=%h active=%0d",
                     redundant_count, dev_state, active_count, m_red, m_state, $countones(m_state));
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (change !== 1'b0 || on_off !== 1'b0) begin
            failures++;
            $display("FAIL reset_event: got change=%0b on_off=%0b, expected 0 0", change, on_off);
        end
        checks++;
        if (dev_state !== '0 || active_count !== 8'd0 || redundant_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got dev_state=%h active=%0d red=%0d, expected 0 0 0",
                     dev_state, active_count, redundant_count);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %0b, expected 1", bus.req_ready);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (pulse_cnt != 0) begin
            failures++;
            $display("FAIL idle_pulses: got %0d, expected 0", pulse_cnt);
        end
    endtask

    task automatic test_single_on();
        int a;
        do_reset();
        push_req(3, 1'b1);
        idle_bus();
        a = acc_cyc;
        wait_pulses(1, 10);
        checks++;
        if (pulse_cyc.size() == 0 || pulse_cyc[0] != a + 2) begin
            failures++;
            $display("FAIL single_latency: got pulse cycle %0d, expected %0d",
                     (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, a + 2);
        end
        settle(10);
        checks++;
        if (dev_state !== 12'h008 || active_count !== 8'd1) begin
            failures++;
            $display("FAIL single_state: got dev_state=%h active=%0d, expected 008 1", dev_state, active_count);
        end
    endtask

    task automatic test_redundant();
        do_reset();
        push_req(3, 1'b1);
        push_req(3, 1'b1);
        push_req(3, 1'b0);
        idle_bus();
        wait_pulses(2, 20);
        settle(10);
        checks++;
        if (redundant_count !== 8'd1 || active_count !== 8'd0 || dev_state !== '0) begin
            failures++;
            $display("FAIL redundant_result: got red=%0d active=%0d dev_state=%h, expected 1 0 000",
                     redundant_count, active_count, dev_state);
        end
    endtask

    task automatic test_invalid_dev();
        do_reset();
        push_req(13, 1'b1);
        push_req(12, 1'b0);
        push_req(15, 1'b1);
        push_req(5, 1'b1);
        idle_bus();
        wait_pulses(1, 20);
        settle(10);
        checks++;
        if (redundant_count !== 8'd3 || dev_state !== 12'h020) begin
            failures++;
            $display("FAIL invalid_dev: got red=%0d dev_state=%h, expected 3 020", redundant_count, dev_state);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        ready_low_seen = 1'b0;
        for (int i = 0; i < 8; i++) push_req(i, 1'b1);
        idle_bus();
        wait_pulses(8, 60);
        checks++;
        if (ready_low_seen !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready: got ready_low_seen=%0b, expected 1", ready_low_seen);
        end
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 1 + GAP_CYCLES) begin
                failures++;
                $display("FAIL bp_spacing: got %0d cycles between pulses %0d and %0d, expected %0d",
                         pulse_cyc[i] - pulse_cyc[i-1], i - 1, i, 1 + GAP_CYCLES);
            end
        end
        settle(10);
        checks++;
        if (dev_state !== 12'h0FF || active_count !== 8'd8) begin
            failures++;
            $display("FAIL bp_state: got dev_state=%h active=%0d, expected 0ff 8", dev_state, active_count);
        end
    endtask

    task automatic test_loopback();
        do_reset();
        for (int i = 0; i < 10; i++) push_req(i, 1'b1);
        for (int i = 0; i < 3; i++)  push_req(i, 1'b0);
        idle_bus();
        wait_pulses(13, 80);
        settle(10);
        checks++;
        if (mon_counter != 7 || active_count !== 8'd7) begin
            failures++;
            $display("FAIL loopback: got monitor=%0d active=%0d, expected 7 7", mon_counter, active_count);
        end
    endtask

    task automatic test_reset_midstream();
        int k;
        int a;
        do_reset();
        for (int i = 0; i < 4; i++) push_req(i, 1'b1);
        idle_bus();
        k = 0;
        while (!change && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!change) begin
            failures++;
            $display("FAIL mid_pulse: got change=%0b before reset, expected 1", change);
        end
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        checks++;
        if (change !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: got change=%0b during reset, expected 0", change);
        end
        checks++;
        if (dev_state !== '0 || active_count !== 8'd0 || redundant_count !== 8'd0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear: got dev_state=%h active=%0d red=%0d ready=%0b, expected 0 0 0 1",
                     dev_state, active_count, redundant_count, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_cnt != 0) begin
            failures++;
            $display("FAIL mid_flushed: got %0d pulses after reset, expected 0", pulse_cnt);
        end
        push_req(0, 1'b1);
        idle_bus();
        a = acc_cyc;
        wait_pulses(1, 10);
        checks++;
        if (pulse_cyc.size() == 0 || pulse_cyc[0] != a + 2) begin
            failures++;
            $display("FAIL mid_latency: got pulse cycle %0d, expected %0d",
                     (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, a + 2);
        end
        settle(10);
        checks++;
        if (dev_state !== 12'h001) begin
            failures++;
            $display("FAIL mid_post: got dev_state=%h, expected 001", dev_state);
        end
    endtask

    task automatic test_random();
        int d;
        bit o;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 5));
            o = 1'($urandom_range(0, 1));
            push_req(d, o);
            if ($urandom_range(0, 3) == 0) begin
                idle_bus();
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        idle_bus();
        settle(40);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) push_req(15, 1'b1);
        idle_bus();
        settle(20);
        checks++;
        if (redundant_count !== 8'd255) begin
            failures++;
            $display("FAIL saturation: got red=%0d, expected 255", redundant_count);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_dev    = '0;
        bus.req_on     = 1'b0;
        ready_low_seen = 1'b0;
        prev_change    = 1'b0;
        clear_model();
        test_reset();
        test_single_on();
        test_redundant();
        test_invalid_dev();
        test_back_pressure();
        test_loopback();
        test_reset_midstream();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
